branch_resolve_unit: RTL and testbench

Consumer and decoder of the 2-bit compare code produced by the ALU for conditional branches. Combines that code with funct3, the unsigned less-than bit and the fetch-stage prediction to resolve branches and jumps in EX. Drives a registered PC redirect and a multi-cycle front-end flush. Holds a 2-bit saturating branch history table (BHT) that the fetch stage reads for prediction.

---
 rtl/branch_resolve_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Resolves conditional branches and jumps in EX. It decodes the ALU's 2-bit
//   compare code together with funct3 and the unsigned less-than bit, then
//   compares the result with the prediction carried down from fetch. On a
//   mispredict it issues a registered one-cycle PC redirect and holds the
//   front-end flush lines high for FLUSH_CYCLES cycles. It also owns the
//   2-bit saturating branch history table (BHT) that fetch reads.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   stall           pipeline stall; blocks resolution and BHT/counter updates
//   if_pc           fetch PC used for the BHT lookup
//   if_pred_taken   prediction for if_pc (MSB of the selected counter)
//   ex_valid        EX holds a real instruction
//   ex_branch       EX instruction is a conditional branch
//   ex_jump         EX instruction is JAL/JALR (always taken)
//   ex_funct3       branch funct3
//   ex_cmp          ALU compare: 01 equal, 11 A>B signed, 10 A<B signed, 00 invalid
//   ex_ltu          unsigned A<B from the ALU
//   ex_pc           PC of the EX instruction
//   ex_target       computed taken target
//   ex_pred_taken   prediction made in fetch for this instruction
//   pc_redirect     one-cycle pulse: fetch must load redirect_pc
//   redirect_pc     corrected next PC
//   flush_if        kill IF/ID register contents
//   flush_id        kill ID/EX register contents
//   illegal_branch  one-cycle pulse: undecodable branch was resolved
//   mispredict_cnt  saturating count of redirects
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_cmp,
    input  logic        ex_ltu,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        illegal_branch,
    output logic [15:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               pc_redirect_q;
    logic [31:0]        redirect_pc_q;
    logic               illegal_q;
    logic [15:0]        mispredict_cnt_q;
    logic [1:0]         bht_q [BHT_ENTRIES];

    logic               resolve;
    logic               branch_taken;
    logic               signed_op;
    logic               undecodable;
    logic               actual_taken;
    logic               mispredict;
    logic               illegal_evt;
    logic               bht_we;
    logic [IDX_W-1:0]   if_idx;
    logic [IDX_W-1:0]   ex_idx;
    logic [1:0]         bht_cur;
    logic [1:0]         bht_next;
    logic [31:0]        next_pc;

    // The BHT is indexed by the word address bits just above the byte offset.
    // Unused PC bits are folded into a sink so they are visibly accounted for.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Fetch-side prediction is a pure combinational read of the stored
    // counter, so a same-cycle update is seen by fetch only after the edge.
    assign if_pred_taken = bht_q[if_idx][1];

    // Decode the branch condition, detect undecodable branches, and work out
    // whether the EX instruction disagrees with its prediction. Jumps are
    // always taken and never touch the BHT or the illegal flag.
    always_comb begin
        resolve      = ex_valid & (ex_branch | ex_jump) & ~stall & (state_q == IDLE);
        branch_taken = 1'b0;
        signed_op    = 1'b0;
        undecodable  = 1'b0;
        case (ex_funct3)
            3'b000: begin
                signed_op    = 1'b1;
                branch_taken = (ex_cmp == 2'b01);
            end
            3'b001: begin
                signed_op    = 1'b1;
                branch_taken = (ex_cmp != 2'b01);
            end
            3'b100: begin
                signed_op    = 1'b1;
                branch_taken = (ex_cmp == 2'b10);
            end
            3'b101: begin
                signed_op    = 1'b1;
                branch_taken = (ex_cmp == 2'b01) | (ex_cmp == 2'b11);
            end
            3'b110:  branch_taken = ex_ltu;
            3'b111:  branch_taken = ~ex_ltu;
            default: undecodable  = 1'b1;
        endcase
        if (signed_op && (ex_cmp == 2'b00)) begin
            undecodable = 1'b1;
        end
        if (undecodable) begin
            branch_taken = 1'b0;
        end
        actual_taken = ex_jump ? 1'b1 : branch_taken;
        mispredict   = resolve & (actual_taken != ex_pred_taken);
        illegal_evt  = resolve & ~ex_jump & ex_branch & undecodable;
        bht_we       = resolve & ~ex_jump & ex_branch & ~undecodable;
        next_pc      = actual_taken ? ex_target : (ex_pc + 32'd4);
    end

    // Saturating 2-bit counter step for the entry addressed by the EX PC.
    always_comb begin
        bht_cur  = bht_q[ex_idx];
        bht_next = bht_cur;
        if (actual_taken) begin
            if (bht_cur != 2'b11) begin
                bht_next = bht_cur + 2'd1;
            end
        end else begin
            if (bht_cur != 2'b00) begin
                bht_next = bht_cur - 2'd1;
            end
        end
    end

    // Flush sequencer: a mispredict enters FLUSH and loads the down-counter
    // so the flush lines stay high for exactly FLUSH_CYCLES cycles. The
    // counter keeps running through stalls so the flush always completes.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d     = FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset clears everything, aborts any flush in progress
    // and returns every BHT entry to weakly not-taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            pc_redirect_q    <= 1'b0;
            redirect_pc_q    <= 32'd0;
            illegal_q        <= 1'b0;
            mispredict_cnt_q <= 16'd0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            pc_redirect_q <= mispredict;
            illegal_q     <= illegal_evt;
            if (mispredict) begin
                redirect_pc_q <= next_pc;
                if (mispredict_cnt_q != 16'hFFFF) begin
                    mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
                end
            end
            if (bht_we) begin
                bht_q[ex_idx] <= bht_next;
            end
        end
    end

    assign pc_redirect    = pc_redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if       = (state_q == FLUSH);
    assign flush_id       = (state_q == FLUSH);
    assign illegal_branch = illegal_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit with default parameters
// (16 BHT entries, 2 flush cycles). Inputs change 1 ns after a rising edge;
// outputs are sampled at the same point, after registered values settle.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_jump;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_cmp;
    logic        ex_ltu;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic        illegal_branch;
    logic [15:0] mispredict_cnt;

    int passCount;
    int totalCount;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_funct3      (ex_funct3),
        .ex_cmp         (ex_cmp),
        .ex_ltu         (ex_ltu),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .pc_redirect    (pc_redirect),
        .redirect_pc    (redirect_pc),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .illegal_branch (illegal_branch),
        .mispredict_cnt (mispredict_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid EX instruction.
    task automatic applyStimulus(input logic br, input logic jp, input logic [2:0] f3,
                                 input logic [1:0] cmp, input logic ltu, input logic [31:0] pc,
                                 input logic [31:0] tgt, input logic pred);
        ex_valid      = 1'b1;
        ex_branch     = br;
        ex_jump       = jp;
        ex_funct3     = f3;
        ex_cmp        = cmp;
        ex_ltu        = ltu;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
    endtask

    task automatic clearEx();
        ex_valid  = 1'b0;
        ex_branch = 1'b0;
        ex_jump   = 1'b0;
    endtask

    // Reset drives every output to zero and the BHT to weakly not-taken.
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL reset_redirect: got %0b want 0", pc_redirect); else passCount++;
        totalCount++; if (redirect_pc !== 32'd0) $display("[TB] FAIL reset_redirect_pc: got %h want 0", redirect_pc); else passCount++;
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL reset_flush_if: got %0b want 0", flush_if); else passCount++;
        totalCount++; if (flush_id !== 1'b0) $display("[TB] FAIL reset_flush_id: got %0b want 0", flush_id); else passCount++;
        totalCount++; if (illegal_branch !== 1'b0) $display("[TB] FAIL reset_illegal: got %0b want 0", illegal_branch); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd0) $display("[TB] FAIL reset_cnt: got %0d want 0", mispredict_cnt); else passCount++;
        if_pc = 32'h0;
        #1;
        totalCount++; if (if_pred_taken !== 1'b0) $display("[TB] FAIL reset_pred_0: got %0b want 0", if_pred_taken); else passCount++;
        if_pc = 32'h3C;
        #1;
        totalCount++; if (if_pred_taken !== 1'b0) $display("[TB] FAIL reset_pred_3c: got %0b want 0", if_pred_taken); else passCount++;
        rst_n = 1'b1;
        tick();
    endtask

    // Taken BEQ predicted not-taken: redirect to target, two flush cycles.
    task automatic test_beq_mispredict();
        if_pc = 32'h100;
        applyStimulus(1'b1, 1'b0, 3'b000, 2'b01, 1'b0, 32'h100, 32'h140, 1'b0);
        #1;
        totalCount++; if (if_pred_taken !== 1'b0) $display("[TB] FAIL beq_pre_update_pred: got %0b want 0", if_pred_taken); else passCount++;
        tick();
        clearEx();
        totalCount++; if (pc_redirect !== 1'b1) $display("[TB] FAIL beq_redirect: got %0b want 1", pc_redirect); else passCount++;
        totalCount++; if (redirect_pc !== 32'h140) $display("[TB] FAIL beq_redirect_pc: got %h want 00000140", redirect_pc); else passCount++;
        totalCount++; if (flush_if !== 1'b1) $display("[TB] FAIL beq_flush_if_c1: got %0b want 1", flush_if); else passCount++;
        totalCount++; if (flush_id !== 1'b1) $display("[TB] FAIL beq_flush_id_c1: got %0b want 1", flush_id); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd1) $display("[TB] FAIL beq_cnt: got %0d want 1", mispredict_cnt); else passCount++;
        totalCount++; if (if_pred_taken !== 1'b1) $display("[TB] FAIL beq_bht_pred: got %0b want 1", if_pred_taken); else passCount++;
        tick();
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL beq_redirect_pulse: got %0b want 0", pc_redirect); else passCount++;
        totalCount++; if (flush_if !== 1'b1) $display("[TB] FAIL beq_flush_if_c2: got %0b want 1", flush_if); else passCount++;
        totalCount++; if (flush_id !== 1'b1) $display("[TB] FAIL beq_flush_id_c2: got %0b want 1", flush_id); else passCount++;
        tick();
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL beq_flush_if_end: got %0b want 0", flush_if); else passCount++;
        totalCount++; if (flush_id !== 1'b0) $display("[TB] FAIL beq_flush_id_end: got %0b want 0", flush_id); else passCount++;
    endtask

    // Correctly predicted BGEU, then a wrapping not-taken BLT mispredict.
    task automatic test_bgeu_blt_wrap();
        applyStimulus(1'b1, 1'b0, 3'b111, 2'b00, 1'b0, 32'h204, 32'h300, 1'b1);
        tick();
        clearEx();
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL bgeu_no_redirect: got %0b want 0", pc_redirect); else passCount++;
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL bgeu_no_flush: got %0b want 0", flush_if); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd1) $display("[TB] FAIL bgeu_cnt: got %0d want 1", mispredict_cnt); else passCount++;
        if_pc = 32'h204;
        #1;
        totalCount++; if (if_pred_taken !== 1'b1) $display("[TB] FAIL bgeu_bht_pred: got %0b want 1", if_pred_taken); else passCount++;
        applyStimulus(1'b1, 1'b0, 3'b100, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h1000, 1'b1);
        tick();
        clearEx();
        totalCount++; if (pc_redirect !== 1'b1) $display("[TB] FAIL blt_redirect: got %0b want 1", pc_redirect); else passCount++;
        totalCount++; if (redirect_pc !== 32'h0) $display("[TB] FAIL blt_wrap_pc: got %h want 00000000", redirect_pc); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd2) $display("[TB] FAIL blt_cnt: got %0d want 2", mispredict_cnt); else passCount++;
        tick();
        tick();
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL blt_flush_end: got %0b want 0", flush_if); else passCount++;
    endtask

    // Undecodable branches pulse illegal_branch and leave the BHT alone.
    task automatic test_illegal();
        if_pc = 32'h100;
        applyStimulus(1'b1, 1'b0, 3'b010, 2'b01, 1'b0, 32'h100, 32'h180, 1'b0);
        tick();
        clearEx();
        totalCount++; if (illegal_branch !== 1'b1) $display("[TB] FAIL illegal_f3_pulse: got %0b want 1", illegal_branch); else passCount++;
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL illegal_f3_redirect: got %0b want 0", pc_redirect); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd2) $display("[TB] FAIL illegal_f3_cnt: got %0d want 2", mispredict_cnt); else passCount++;
        totalCount++; if (if_pred_taken !== 1'b1) $display("[TB] FAIL illegal_f3_bht: got %0b want 1", if_pred_taken); else passCount++;
        tick();
        totalCount++; if (illegal_branch !== 1'b0) $display("[TB] FAIL illegal_f3_once: got %0b want 0", illegal_branch); else passCount++;
        applyStimulus(1'b1, 1'b0, 3'b001, 2'b00, 1'b0, 32'h100, 32'h180, 1'b0);
        tick();
        clearEx();
        totalCount++; if (illegal_branch !== 1'b1) $display("[TB] FAIL illegal_bne_pulse: got %0b want 1", illegal_branch); else passCount++;
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL illegal_bne_redirect: got %0b want 0", pc_redirect); else passCount++;
        totalCount++; if (if_pred_taken !== 1'b1) $display("[TB] FAIL illegal_bne_bht: got %0b want 1", if_pred_taken); else passCount++;
        tick();
        totalCount++; if (illegal_branch !== 1'b0) $display("[TB] FAIL illegal_bne_once: got %0b want 0", illegal_branch); else passCount++;
    endtask

    // A jump overrides branch decode: taken, never illegal, no BHT write.
    task automatic test_jump();
        if_pc = 32'h120;
        applyStimulus(1'b1, 1'b1, 3'b010, 2'b00, 1'b0, 32'h120, 32'h800, 1'b0);
        tick();
        clearEx();
        totalCount++; if (pc_redirect !== 1'b1) $display("[TB] FAIL jump_redirect: got %0b want 1", pc_redirect); else passCount++;
        totalCount++; if (redirect_pc !== 32'h800) $display("[TB] FAIL jump_redirect_pc: got %h want 00000800", redirect_pc); else passCount++;
        totalCount++; if (illegal_branch !== 1'b0) $display("[TB] FAIL jump_not_illegal: got %0b want 0", illegal_branch); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd3) $display("[TB] FAIL jump_cnt: got %0d want 3", mispredict_cnt); else passCount++;
        totalCount++; if (if_pred_taken !== 1'b0) $display("[TB] FAIL jump_no_bht: got %0b want 0", if_pred_taken); else passCount++;
        tick();
        tick();
    endtask

    // A second mispredict arriving during FLUSH is ignored.
    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b0, 3'b000, 2'b10, 1'b0, 32'h40C, 32'h600, 1'b1);
        tick();
        totalCount++; if (pc_redirect !== 1'b1) $display("[TB] FAIL b2b_first_redirect: got %0b want 1", pc_redirect); else passCount++;
        totalCount++; if (redirect_pc !== 32'h410) $display("[TB] FAIL b2b_first_pc: got %h want 00000410", redirect_pc); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd4) $display("[TB] FAIL b2b_first_cnt: got %0d want 4", mispredict_cnt); else passCount++;
        applyStimulus(1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 32'h700, 32'h900, 1'b0);
        tick();
        clearEx();
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL b2b_second_ignored: got %0b want 0", pc_redirect); else passCount++;
        totalCount++; if (redirect_pc !== 32'h410) $display("[TB] FAIL b2b_pc_held: got %h want 00000410", redirect_pc); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd4) $display("[TB] FAIL b2b_cnt_held: got %0d want 4", mispredict_cnt); else passCount++;
        totalCount++; if (flush_if !== 1'b1) $display("[TB] FAIL b2b_flush_c2: got %0b want 1", flush_if); else passCount++;
        tick();
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL b2b_flush_end: got %0b want 0", flush_if); else passCount++;
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL b2b_no_late_redirect: got %0b want 0", pc_redirect); else passCount++;
    endtask

    // Stall holds off resolution; stall during a flush does not extend it.
    task automatic test_stall();
        stall = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b000, 2'b01, 1'b0, 32'h104, 32'h500, 1'b0);
        tick();
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL stall_no_redirect_c1: got %0b want 0", pc_redirect); else passCount++;
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL stall_no_flush: got %0b want 0", flush_if); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd4) $display("[TB] FAIL stall_cnt_held: got %0d want 4", mispredict_cnt); else passCount++;
        tick();
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL stall_no_redirect_c2: got %0b want 0", pc_redirect); else passCount++;
        stall = 1'b0;
        tick();
        clearEx();
        totalCount++; if (pc_redirect !== 1'b1) $display("[TB] FAIL stall_release_redirect: got %0b want 1", pc_redirect); else passCount++;
        totalCount++; if (redirect_pc !== 32'h500) $display("[TB] FAIL stall_release_pc: got %h want 00000500", redirect_pc); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd5) $display("[TB] FAIL stall_release_cnt: got %0d want 5", mispredict_cnt); else passCount++;
        stall = 1'b1;
        tick();
        totalCount++; if (flush_if !== 1'b1) $display("[TB] FAIL stall_flush_c2: got %0b want 1", flush_if); else passCount++;
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL stall_redirect_pulse: got %0b want 0", pc_redirect); else passCount++;
        tick();
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL stall_flush_not_frozen: got %0b want 0", flush_if); else passCount++;
        stall = 1'b0;
    endtask

    // BHT counters saturate at 11 and at 00.
    task automatic test_saturation();
        if_pc = 32'h110;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 3'b000, 2'b01, 1'b0, 32'h110, 32'h200, 1'b1);
            tick();
            totalCount++; if (if_pred_taken !== 1'b1) $display("[TB] FAIL sat_up_pred_%0d: got %0b want 1", i, if_pred_taken); else passCount++;
            totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL sat_up_redirect_%0d: got %0b want 0", i, pc_redirect); else passCount++;
        end
        applyStimulus(1'b1, 1'b0, 3'b000, 2'b10, 1'b0, 32'h110, 32'h200, 1'b0);
        tick();
        totalCount++; if (if_pred_taken !== 1'b1) $display("[TB] FAIL sat_top_held: got %0b want 1", if_pred_taken); else passCount++;
        tick();
        clearEx();
        totalCount++; if (if_pred_taken !== 1'b0) $display("[TB] FAIL sat_down_to_01: got %0b want 0", if_pred_taken); else passCount++;
        if_pc = 32'h13C;
        applyStimulus(1'b1, 1'b0, 3'b111, 2'b00, 1'b1, 32'h13C, 32'h200, 1'b0);
        tick();
        totalCount++; if (if_pred_taken !== 1'b0) $display("[TB] FAIL sat_bottom_held: got %0b want 0", if_pred_taken); else passCount++;
        applyStimulus(1'b1, 1'b0, 3'b000, 2'b01, 1'b0, 32'h13C, 32'h200, 1'b1);
        tick();
        totalCount++; if (if_pred_taken !== 1'b0) $display("[TB] FAIL sat_bottom_to_01: got %0b want 0", if_pred_taken); else passCount++;
        tick();
        clearEx();
        totalCount++; if (if_pred_taken !== 1'b1) $display("[TB] FAIL sat_bottom_to_10: got %0b want 1", if_pred_taken); else passCount++;
    endtask

    // Reset in the middle of a flush drops everything on the next edge.
    task automatic test_reset_mid_flush();
        applyStimulus(1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 32'h140, 32'hA00, 1'b0);
        tick();
        clearEx();
        totalCount++; if (flush_if !== 1'b1) $display("[TB] FAIL rmf_flush_started: got %0b want 1", flush_if); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd6) $display("[TB] FAIL rmf_cnt_before: got %0d want 6", mispredict_cnt); else passCount++;
        rst_n = 1'b0;
        tick();
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL rmf_flush_if: got %0b want 0", flush_if); else passCount++;
        totalCount++; if (flush_id !== 1'b0) $display("[TB] FAIL rmf_flush_id: got %0b want 0", flush_id); else passCount++;
        totalCount++; if (pc_redirect !== 1'b0) $display("[TB] FAIL rmf_redirect: got %0b want 0", pc_redirect); else passCount++;
        totalCount++; if (redirect_pc !== 32'd0) $display("[TB] FAIL rmf_redirect_pc: got %h want 0", redirect_pc); else passCount++;
        totalCount++; if (mispredict_cnt !== 16'd0) $display("[TB] FAIL rmf_cnt: got %0d want 0", mispredict_cnt); else passCount++;
        if_pc = 32'h104;
        #1;
        totalCount++; if (if_pred_taken !== 1'b0) $display("[TB] FAIL rmf_bht_reset: got %0b want 0", if_pred_taken); else passCount++;
        rst_n = 1'b1;
        tick();
        totalCount++; if (flush_if !== 1'b0) $display("[TB] FAIL rmf_flush_stays_low: got %0b want 0", flush_if); else passCount++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        passCount     = 0;
        totalCount    = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        if_pc         = 32'h0;
        ex_valid      = 1'b0;
        ex_branch     = 1'b0;
        ex_jump       = 1'b0;
        ex_funct3     = 3'b000;
        ex_cmp        = 2'b00;
        ex_ltu        = 1'b0;
        ex_pc         = 32'h0;
        ex_target     = 32'h0;
        ex_pred_taken = 1'b0;
        test_reset();
        test_beq_mispredict();
        test_bgeu_blt_wrap();
        test_illegal();
        test_jump();
        test_back_to_back();
        test_stall();
        test_saturation();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
